lfm_chirp_generator: RTL and testbench
======================================

LFM_CHIRP_GENERATOR -- requirements
Module: lfm_chirp_generator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12, setting the sample width in bits.
REQ-002 SHALL have parameter PULSE_LENGTH, default 800, setting the number of chirp samples per frame.
REQ-003 SHALL have parameter FRAME_LENGTH, default 7700, setting the total samples per frame (chirp plus listen); FRAME_LENGTH > PULSE_LENGTH.
REQ-004 SHALL have parameter PHASE_WIDTH, default 32, setting the phase and frequency accumulator width.
REQ-005 SHALL have parameter LUT_ADDR_WIDTH, default 10, setting the quarter-wave address width.
REQ-006 clock  input  1  sole clock; all logic on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 enable  input  1  permits frame start and continuous re-arm.
REQ-009 start  input  1  single-cycle request to begin a frame.
REQ-010 continuous  input  1  re-arm the next frame automatically at frame end.
REQ-011 freqStart  input  PHASE_WIDTH  start frequency word (unsigned, fraction of fs).
REQ-012 chirpRate  input  PHASE_WIDTH  per-sample frequency increment (two's complement).
REQ-013 txOut  output  DATA_WIDTH  signed transmit sample.
REQ-014 txValid  output  1  txOut holds a frame sample.
REQ-015 pulseActive  output  1  txOut holds a chirp sample (not a listen sample).
REQ-016 pulseDoneFlag  output  1  one-cycle strobe coincident with the last chirp sample.
REQ-017 busy  output  1  FSM is not IDLE.
REQ-018 frameCount  output  16  number of completed frames, wraps modulo 2^16.

Function
REQ-019 FSM states SHALL be IDLE, PULSE and LISTEN.
REQ-020 In IDLE, start=1 with enable=1 SHALL latch freqStart and chirpRate, clear phase and sample counter, and enter PULSE.
REQ-021 start while busy=1 SHALL be ignored.
REQ-022 Chirp sample n (0..PULSE_LENGTH-1) SHALL use phase_n = n*freqStart + chirpRate*n*(n-1)/2 mod 2^PHASE_WIDTH, computed by phase+=freq then freq+=chirpRate.
REQ-023 Accumulator overflow SHALL wrap silently, with no saturation.
REQ-024 txOut SHALL be round(A*sin(2*pi*phase_n/2^PHASE_WIDTH)) with A = 2^(DATA_WIDTH-1)-1; -2^(DATA_WIDTH-1) SHALL never be produced.
REQ-025 Only the top LUT_ADDR_WIDTH+2 phase bits SHALL address the LUT, with no dithering.
REQ-026 PULSE SHALL last PULSE_LENGTH cycles, then go to LISTEN for FRAME_LENGTH-PULSE_LENGTH cycles.
REQ-027 Listen samples SHALL be txOut=0, txValid=1, pulseActive=0.
REQ-028 Pipeline latency SHALL be fixed: the first sample appears on txOut, with txValid=1, exactly 3 cycles after the cycle start is sampled.
REQ-029 txValid, pulseActive and pulseDoneFlag SHALL be delayed by the same 3-cycle latency as the data path.
REQ-030 Each frame SHALL be exactly FRAME_LENGTH consecutive txValid cycles with no gaps.
REQ-031 At the end of LISTEN, frameCount SHALL increment.
REQ-032 At the end of LISTEN, continuous=1 with enable=1 SHALL re-enter PULSE on the next cycle, re-latching freqStart and chirpRate, so that frames are back-to-back.
REQ-033 At the end of LISTEN, any other continuous/enable combination SHALL return the FSM to IDLE.
REQ-034 Deasserting enable mid-frame SHALL NOT abort the frame; the frame completes, then the FSM returns to IDLE.
REQ-035 Changes to freqStart or chirpRate mid-frame SHALL have no effect until the next latch.
REQ-036 In IDLE, txOut SHALL be 0 and txValid, pulseActive and pulseDoneFlag SHALL be 0 once the pipeline has drained.

Reset
REQ-037 reset SHALL dominate all other inputs and take effect on the next edge, including mid-pulse.
REQ-038 Reset values: state=IDLE; txOut=0; txValid=0; pulseActive=0; pulseDoneFlag=0; busy=0; frameCount=0; accumulators=0; pipeline registers=0.
REQ-039 No partial frame SHALL be output after reset; the 3-stage pipeline SHALL be flushed to 0.

Structure
REQ-040 A shared package SHALL hold the FSM state encoding, default PHASE_WIDTH and LUT_ADDR_WIDTH, and the amplitude constant A.
REQ-041 The FSM, accumulators and counters SHALL live in lfm_chirp_generator.
REQ-042 One sub-module, sine_lut, SHALL provide a quarter-wave registered ROM with 1-cycle latency and handle sign/quadrant mirroring internally.
REQ-043 Frequency settings SHALL be consistent with the matched-filter coefficient generation (PULSE_LENGTH = COEFF_LENGTH).

Verification
REQ-044 freqStart=2^30 (fs/4), chirpRate=0, start -> txOut = 0,2047,0,-2047 repeating for 800 samples, then 6900 zeros; pulseDoneFlag on sample 799; frameCount=1.
REQ-045 freqStart=0, chirpRate=0 -> 7700 zero samples with txValid=1, pulseActive high for exactly 800 cycles, pulseDoneFlag still strobes once.
REQ-046 freqStart=2^24, chirpRate=2^14 -> every chirp sample matches the bit-exact golden model of REQ-022/REQ-024; no -2048 value.
REQ-047 start pulsed again at sample 100 and at sample 5000 -> both ignored; frame length stays 7700.
REQ-048 continuous=1 for 3 frames, enable dropped during frame 3 -> 23100 contiguous txValid cycles, frameCount=3, then IDLE.
REQ-049 reset asserted at sample 400 of the chirp -> next cycle all outputs 0 and busy=0; a new start afterwards produces a full correct frame.

Source files
------------

// File: rtl/lfm_chirp_generator_pkg.sv
// Shared definitions for the LFM chirp generator: FSM encoding, default widths,
// amplitude and the quarter-wave sine table entry function.
package lfm_chirp_generator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PULSE  = 2'd1,
        ST_LISTEN = 2'd2
    } chirp_state_t;

    localparam int DEFAULT_DATA_WIDTH     = 12;
    localparam int DEFAULT_PHASE_WIDTH    = 32;
    localparam int DEFAULT_LUT_ADDR_WIDTH = 10;

    localparam real PI = 3.14159265358979323846;

    function automatic int amplitude(input int dw);
        return (1 << (dw - 1)) - 1;
    endfunction

    localparam int AMPLITUDE = amplitude(DEFAULT_DATA_WIDTH);

    // First-quadrant magnitude for table index idx, rounded to nearest.
    function automatic int sine_entry(input int idx, input int lut_aw, input int dw);
        real angle;
        angle = 2.0 * PI * real'(idx) / real'(4 * (1 << lut_aw));
        return $rtoi(real'(amplitude(dw)) * $sin(angle) + 0.5);
    endfunction

endpackage

// File: rtl/lfm_chirp_generator_sine_lut.sv
// Quarter-wave sine ROM with registered output; quadrant mirroring and sign
// are resolved inside so callers pass the raw top phase bits.
module sine_lut
    import lfm_chirp_generator_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int LUT_ADDR_WIDTH = DEFAULT_LUT_ADDR_WIDTH
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [LUT_ADDR_WIDTH+1:0]     phase_addr,
    output logic signed [DATA_WIDTH-1:0]  sample
);

    localparam int MAG_W = DATA_WIDTH - 1;
    localparam int DEPTH = 1 << LUT_ADDR_WIDTH;

    logic [MAG_W-1:0] rom [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        assign rom[i] = MAG_W'(sine_entry(i, LUT_ADDR_WIDTH, DATA_WIDTH));
    end

    logic [1:0]                quadrant;
    logic [LUT_ADDR_WIDTH-1:0] idx;
    logic [LUT_ADDR_WIDTH-1:0] idx_mirror;
    logic                      at_peak;
    logic [MAG_W-1:0]          mag;

    assign quadrant   = phase_addr[LUT_ADDR_WIDTH+1:LUT_ADDR_WIDTH];
    assign idx        = phase_addr[LUT_ADDR_WIDTH-1:0];
    assign idx_mirror = quadrant[0] ? (LUT_ADDR_WIDTH'(0) - idx) : idx;
    // The descending quadrants at index 0 land on the crest, one past the table.
    assign at_peak    = quadrant[0] && (idx == '0);
    assign mag        = at_peak ? MAG_W'(amplitude(DATA_WIDTH)) : rom[idx_mirror];

    always_ff @(posedge clock) begin
        if (reset) begin
            sample <= '0;
        end else if (quadrant[1]) begin
            sample <= -$signed({1'b0, mag});
        end else begin
            sample <= $signed({1'b0, mag});
        end
    end

endmodule

// File: rtl/lfm_chirp_generator.sv
// Linear-FM chirp generator: PULSE/LISTEN frame sequencer with quadratic phase
// accumulation feeding a 3-stage sine pipeline.
//
//   state     | meaning
//   ST_IDLE   | waiting for start with enable
//   ST_PULSE  | emitting chirp samples, accumulators running
//   ST_LISTEN | emitting zero samples until frame end
module lfm_chirp_generator
    import lfm_chirp_generator_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int PULSE_LENGTH   = 800,
    parameter int FRAME_LENGTH   = 7700,
    parameter int PHASE_WIDTH    = DEFAULT_PHASE_WIDTH,
    parameter int LUT_ADDR_WIDTH = DEFAULT_LUT_ADDR_WIDTH
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          start,
    input  logic                          continuous,
    input  logic [PHASE_WIDTH-1:0]        freqStart,
    input  logic [PHASE_WIDTH-1:0]        chirpRate,
    output logic signed [DATA_WIDTH-1:0]  txOut,
    output logic                          txValid,
    output logic                          pulseActive,
    output logic                          pulseDoneFlag,
    output logic                          busy,
    output logic [15:0]                   frameCount
);

    localparam int CNT_W  = $clog2(FRAME_LENGTH);
    localparam int ADDR_W = LUT_ADDR_WIDTH + 2;
    localparam logic [CNT_W-1:0] PULSE_LOAD  = CNT_W'(PULSE_LENGTH - 1);
    localparam logic [CNT_W-1:0] LISTEN_LOAD = CNT_W'(FRAME_LENGTH - PULSE_LENGTH - 1);

    chirp_state_t           state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic [PHASE_WIDTH-1:0] phase, phase_nxt;
    logic [PHASE_WIDTH-1:0] freq, freq_nxt;
    logic [PHASE_WIDTH-1:0] rate, rate_nxt;
    logic [15:0]            frame_cnt, frame_cnt_nxt;
    logic                   tc;

    assign tc = (cnt == '0);

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        phase_nxt     = phase;
        freq_nxt      = freq;
        rate_nxt      = rate;
        frame_cnt_nxt = frame_cnt;
        case (state)
            ST_IDLE: begin
                if (start && enable) begin
                    state_nxt = ST_PULSE;
                    cnt_nxt   = PULSE_LOAD;
                    phase_nxt = '0;
                    freq_nxt  = freqStart;
                    rate_nxt  = chirpRate;
                end
            end
            ST_PULSE: begin
                phase_nxt = phase + freq;
                freq_nxt  = freq + rate;
                if (tc) begin
                    state_nxt = ST_LISTEN;
                    cnt_nxt   = LISTEN_LOAD;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            ST_LISTEN: begin
                if (tc) begin
                    frame_cnt_nxt = frame_cnt + 16'd1;
                    // Re-arm directly into PULSE so consecutive frames abut.
                    if (continuous && enable) begin
                        state_nxt = ST_PULSE;
                        cnt_nxt   = PULSE_LOAD;
                        phase_nxt = '0;
                        freq_nxt  = freqStart;
                        rate_nxt  = chirpRate;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            phase     <= '0;
            freq      <= '0;
            rate      <= '0;
            frame_cnt <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            phase     <= phase_nxt;
            freq      <= freq_nxt;
            rate      <= rate_nxt;
            frame_cnt <= frame_cnt_nxt;
        end
    end

    logic              s1_valid, s1_active, s1_done;
    logic [ADDR_W-1:0] s1_addr;
    logic              s2_valid, s2_active, s2_done;
    logic signed [DATA_WIDTH-1:0] lut_sample;

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid      <= 1'b0;
            s1_active     <= 1'b0;
            s1_done       <= 1'b0;
            s1_addr       <= '0;
            s2_valid      <= 1'b0;
            s2_active     <= 1'b0;
            s2_done       <= 1'b0;
            txOut         <= '0;
            txValid       <= 1'b0;
            pulseActive   <= 1'b0;
            pulseDoneFlag <= 1'b0;
        end else begin
            s1_valid      <= (state != ST_IDLE);
            s1_active     <= (state == ST_PULSE);
            s1_done       <= (state == ST_PULSE) && tc;
            s1_addr       <= (state == ST_PULSE) ? phase[PHASE_WIDTH-1 -: ADDR_W] : '0;
            s2_valid      <= s1_valid;
            s2_active     <= s1_active;
            s2_done       <= s1_done;
            txOut         <= s2_active ? lut_sample : '0;
            txValid       <= s2_valid;
            pulseActive   <= s2_active;
            pulseDoneFlag <= s2_done;
        end
    end

    sine_lut #(
        .DATA_WIDTH     (DATA_WIDTH),
        .LUT_ADDR_WIDTH (LUT_ADDR_WIDTH)
    ) u_sine_lut (
        .clock      (clock),
        .reset      (reset),
        .phase_addr (s1_addr),
        .sample     (lut_sample)
    );

    assign busy       = (state != ST_IDLE);
    assign frameCount = frame_cnt;

endmodule

// File: tb/tb_lfm_chirp_generator.sv
// Scoreboard bench for lfm_chirp_generator: expected frames are queued at start
// time from a closed-form chirp model and popped by an output monitor.
module tb_lfm_chirp_generator;

    localparam int PL = 800;
    localparam int FL = 7700;
    localparam real TB_PI = 3.14159265358979323846;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               enable = 1'b0;
    logic               start = 1'b0;
    logic               continuous = 1'b0;
    logic [31:0]        freqStart = '0;
    logic [31:0]        chirpRate = '0;
    logic signed [11:0] txOut;
    logic               txValid;
    logic               pulseActive;
    logic               pulseDoneFlag;
    logic               busy;
    logic [15:0]        frameCount;

    lfm_chirp_generator dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .start         (start),
        .continuous    (continuous),
        .freqStart     (freqStart),
        .chirpRate     (chirpRate),
        .txOut         (txOut),
        .txValid       (txValid),
        .pulseActive   (pulseActive),
        .pulseDoneFlag (pulseDoneFlag),
        .busy          (busy),
        .frameCount    (frameCount)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int                 at;
        logic signed [11:0] data;
        logic               active;
        logic               done;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   exp_frames = 0;

    function automatic exp_t model(input logic [31:0] f, input logic [31:0] r, input int n, input int at);
        exp_t        e;
        logic [63:0] ph;
        int          k;
        real         x;
        e.at     = at;
        e.active = (n < PL);
        e.done   = (n == PL - 1);
        e.data   = '0;
        if (n < PL) begin
            ph = 64'(n) * 64'(f) + 64'(r) * 64'((n * (n - 1)) / 2);
            k  = int'(ph[31:20]);
            x  = 2047.0 * $sin(2.0 * TB_PI * real'(k) / 4096.0);
            if (x >= 0.0) e.data = 12'($rtoi(x + 0.5));
            else          e.data = -12'($rtoi(-x + 0.5));
        end
        return e;
    endfunction

    task automatic push_frame(input logic [31:0] f, input logic [31:0] r, input int base);
        for (int n = 0; n < FL; n++) exp_q.push_back(model(f, r, n, base + n));
        exp_frames++;
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (txValid) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_sample: cycle %0d txOut %0d, no sample was expected", cyc, txOut);
            end else begin
                e = exp_q.pop_front();
                if (cyc != e.at || txOut != e.data || pulseActive != e.active || pulseDoneFlag != e.done) begin
                    miscompares++;
                    $display("FAIL sample: cycle %0d txOut %0d act %0b done %0b, expected cycle %0d txOut %0d act %0b done %0b",
                             cyc, txOut, pulseActive, pulseDoneFlag, e.at, e.data, e.active, e.done);
                end
            end
        end else if (txOut != 0 || pulseActive || pulseDoneFlag) begin
            vectors++;
            miscompares++;
            $display("FAIL idle_outputs: cycle %0d txOut %0d act %0b done %0b, expected all 0",
                     cyc, txOut, pulseActive, pulseDoneFlag);
        end
    end

    task automatic chk(input string name, input longint act, input longint expv);
        vectors++;
        if (act != expv) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) tick();
    endtask

    task automatic issue_start(input logic [31:0] f, input logic [31:0] r, output int c);
        freqStart = f;
        chirpRate = r;
        enable    = 1'b1;
        start     = 1'b1;
        c         = cyc;
        tick();
        start     = 1'b0;
    endtask

    task automatic drain_and_check(input string name);
        int k = 0;
        while (exp_q.size() != 0 && k < 3 * FL + 100) begin
            tick();
            k++;
        end
        repeat (4) tick();
        chk({name, "_drain_left"}, exp_q.size(), 0);
        chk({name, "_frameCount"}, frameCount, 16'(exp_frames));
        chk({name, "_busy"}, busy, 0);
        chk({name, "_txValid"}, txValid, 0);
    endtask

    initial begin
        int c;
        logic [31:0] f, r;
        #(100000 * 10);
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int          c;
        logic [31:0] f, r;

        repeat (3) tick();
        chk("reset_txOut", txOut, 0);
        chk("reset_txValid", txValid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_frameCount", frameCount, 0);
        reset = 1'b0;
        tick();

        // Quarter-rate tone, no sweep.
        issue_start(32'h4000_0000, 32'h0, c);
        push_frame(32'h4000_0000, 32'h0, c + 4);
        chk("tone_busy", busy, 1);
        drain_and_check("tone");

        // DC: all-zero chirp, flags still framed.
        issue_start(32'h0, 32'h0, c);
        push_frame(32'h0, 32'h0, c + 4);
        drain_and_check("dc");

        // Fixed sweep.
        issue_start(32'h0100_0000, 32'h0000_4000, c);
        push_frame(32'h0100_0000, 32'h0000_4000, c + 4);
        drain_and_check("sweep");

        // Random sweep with starts (and input changes) while busy.
        f = $urandom;
        r = $urandom;
        issue_start(f, r, c);
        push_frame(f, r, c + 4);
        wait_until(c + 4 + 100);
        start = 1'b1; freqStart = $urandom; chirpRate = $urandom;
        tick();
        start = 1'b0;
        wait_until(c + 4 + 5000);
        start = 1'b1; freqStart = $urandom;
        tick();
        start = 1'b0;
        drain_and_check("busy_start");

        // Three back-to-back frames; settings changed in frame 1 apply from frame 2.
        f = $urandom;
        r = $urandom;
        continuous = 1'b1;
        issue_start(f, r, c);
        push_frame(f, r, c + 4);
        wait_until(c + 4 + 3000);
        f = $urandom;
        r = $urandom;
        freqStart = f;
        chirpRate = r;
        push_frame(f, r, c + 4 + FL);
        push_frame(f, r, c + 4 + 2 * FL);
        wait_until(c + 4 + 2 * FL + 1000);
        enable = 1'b0;
        chk("cont_busy_after_enable_drop", busy, 1);
        drain_and_check("continuous");
        continuous = 1'b0;

        // Reset in mid-chirp, with start held to show reset wins.
        f = $urandom;
        r = $urandom;
        issue_start(f, r, c);
        push_frame(f, r, c + 4);
        wait_until(c + 4 + 400);
        reset = 1'b1;
        start = 1'b1;
        tick();
        exp_q.delete();
        exp_frames = 0;
        chk("rst_txOut", txOut, 0);
        chk("rst_txValid", txValid, 0);
        chk("rst_pulseActive", pulseActive, 0);
        chk("rst_pulseDone", pulseDoneFlag, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frameCount", frameCount, 0);
        reset = 1'b0;
        start = 1'b0;
        tick();
        f = $urandom;
        r = $urandom;
        issue_start(f, r, c);
        push_frame(f, r, c + 4);
        drain_and_check("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
